// File: rtl/r16_modred_pipe_ctrl.sv
// Sequencer for the radix-16 modular-reduction pipeline: stage enables, per-stage valids,
// backpressure and drain-before-reload modulus broadcast. Define R16_MODRED_CTRL_PERF_EN for a stall counter.
`timescale 1ns/1ps
module r16_modred_pipe_ctrl #(
    parameter int unsigned P_WIDTH  = 64,
    parameter int unsigned P_STAGES = 4,
    parameter int unsigned P_OCC_W  = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [P_WIDTH-1:0]  cfg_n,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                stage_en,
    output logic [P_STAGES-1:0] stage_vld,
    output logic [P_WIDTH-1:0]  n_cur,
    output logic [P_OCC_W-1:0]  occupancy,
    output logic                busy
`ifdef R16_MODRED_CTRL_PERF_EN
    ,
    input  logic                stall_clr,
    output logic [31:0]         stall_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DRAIN} state_t;

    state_t               state, state_nxt;
    logic [P_WIDTH-1:0]   pending;
    logic                 advance, acc_in, retire, cfg_acc;
    logic                 pending_ld, n_ld;
    logic [P_OCC_W-1:0]   occ_nxt;

    assign advance   = ~stage_vld[P_STAGES-1] | out_ready;
    assign stage_en  = advance;
    assign out_valid = stage_vld[P_STAGES-1];
    assign in_ready  = (state == RUN) & advance;
    assign cfg_ready = (state == IDLE) | (state == RUN);
    assign acc_in    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;
    assign cfg_acc   = cfg_valid & cfg_ready;
    assign occ_nxt   = occupancy + P_OCC_W'(acc_in) - P_OCC_W'(retire);
    assign busy      = (state != IDLE) | (occupancy != '0);

    // A new modulus only goes live once every in-flight operand has left the pipe.
    always_comb begin
        state_nxt  = state;
        pending_ld = 1'b0;
        n_ld       = 1'b0;
        case (state)
            IDLE: begin
                if (cfg_acc) begin
                    pending_ld = 1'b1;
                    state_nxt  = LOAD;
                end
            end
            LOAD: begin
                n_ld      = 1'b1;
                state_nxt = RUN;
            end
            RUN: begin
                if (cfg_acc) begin
                    pending_ld = 1'b1;
                    state_nxt  = (occ_nxt == '0) ? LOAD : DRAIN;
                end
            end
            DRAIN: begin
                if (occ_nxt == '0) state_nxt = LOAD;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            stage_vld <= '0;
            occupancy <= '0;
            pending   <= '0;
            n_cur     <= '0;
        end else begin
            state     <= state_nxt;
            occupancy <= occ_nxt;
            if (advance) stage_vld <= {stage_vld[P_STAGES-2:0], acc_in};
            if (pending_ld) pending <= cfg_n;
            if (n_ld) n_cur <= pending;
        end
    end

`ifdef R16_MODRED_CTRL_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_clr)
            stall_cnt <= '0;
        else if (out_valid & ~out_ready & (stall_cnt != 32'hFFFF_FFFF))
            stall_cnt <= stall_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_r16_modred_pipe_ctrl.sv
// Scoreboard bench for r16_modred_pipe_ctrl: a shadow datapath clocked by stage_en tags operands
// with id and modulus; the monitor checks retire order and modulus against queued expectations.
`timescale 1ns/1ps
module tb_r16_modred_pipe_ctrl;
    localparam int P_WIDTH = 64, P_STAGES = 4, P_OCC_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n, cfg_valid, cfg_ready, in_valid, in_ready;
    logic                out_valid, out_ready, stage_en, busy;
    logic [P_WIDTH-1:0]  cfg_n, n_cur;
    logic [P_STAGES-1:0] stage_vld;
    logic [P_OCC_W-1:0]  occupancy;
`ifdef R16_MODRED_CTRL_PERF_EN
    logic                stall_clr;
    logic [31:0]         stall_cnt;
`endif

    r16_modred_pipe_ctrl #(.P_WIDTH(P_WIDTH), .P_STAGES(P_STAGES), .P_OCC_W(P_OCC_W)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_n(cfg_n),
        .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid), .out_ready(out_ready),
        .stage_en(stage_en), .stage_vld(stage_vld), .n_cur(n_cur), .occupancy(occupancy),
        .busy(busy)
`ifdef R16_MODRED_CTRL_PERF_EN
        , .stall_clr(stall_clr), .stall_cnt(stall_cnt)
`endif
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] id;
        logic [63:0] n;
    } exp_t;
    exp_t sb[$];

    logic [15:0] in_id;
    logic [63:0] exp_n;
    logic [15:0] dp_id [P_STAGES];
    logic [63:0] dp_n  [P_STAGES];

    // Shadow datapath: operand tag and the modulus it entered with travel on stage_en.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < P_STAGES; i++) begin
                dp_id[i] <= '0;
                dp_n[i]  <= '0;
            end
        end else if (stage_en) begin
            dp_id[0] <= in_id;
            dp_n[0]  <= n_cur;
            for (int i = 1; i < P_STAGES; i++) begin
                dp_id[i] <= dp_id[i-1];
                dp_n[i]  <= dp_n[i-1];
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (rst_n) begin
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL retire_unexpected: got id %0h expected no retire", dp_id[P_STAGES-1]);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        check("retire_id", 64'(dp_id[P_STAGES-1]), 64'(e.id));
                        check("retire_n", dp_n[P_STAGES-1], e.n);
                    end
                end
                if (in_valid && in_ready) sb.push_back({in_id, exp_n});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    int first_ov, last_ov, ov_cnt, max_occ;

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_n = '0; in_valid = 1'b0; in_id = '0;
        out_ready = 1'b1; exp_n = '0;
`ifdef R16_MODRED_CTRL_PERF_EN
        stall_clr = 1'b0;
`endif
        smp();
        check("rst_cfg_ready", 64'(cfg_ready), 1);
        check("rst_in_ready", 64'(in_ready), 0);
        check("rst_out_valid", 64'(out_valid), 0);
        check("rst_stage_en", 64'(stage_en), 1);
        check("rst_busy", 64'(busy), 0);
        check("rst_occ", 64'(occupancy), 0);
        check("rst_n_cur", n_cur, 0);
        check("rst_stage_vld", 64'(stage_vld), 0);

        // Initial modulus load
        cyc(); rst_n = 1'b1; cfg_valid = 1'b1; cfg_n = 64'h0000_0000_FFFF_FFFF;
        smp(); check("idle_cfg_ready", 64'(cfg_ready), 1);
        cyc(); cfg_valid = 1'b0;
        smp();
        check("load_cfg_ready", 64'(cfg_ready), 0);
        check("load_in_ready", 64'(in_ready), 0);
        check("load_n_cur_old", n_cur, 0);
        check("load_busy", 64'(busy), 1);
        cyc(); smp();
        check("run_n_cur", n_cur, 64'hFFFF_FFFF);
        check("run_in_ready", 64'(in_ready), 1);

        // Stream 10 operands without backpressure
        exp_n = 64'hFFFF_FFFF;
        first_ov = -1; last_ov = -1; ov_cnt = 0; max_occ = 0;
        for (int c = 0; c < 16; c++) begin
            cyc(); in_valid = (c < 10); in_id = 16'(c);
            smp();
            if (out_valid) begin
                if (first_ov < 0) first_ov = c;
                last_ov = c;
                ov_cnt++;
            end
            if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
        end
        check("stream_latency", 64'(first_ov), 4);
        check("stream_ov_count", 64'(ov_cnt), 10);
        check("stream_ov_last", 64'(last_ov), 13);
        check("stream_occ_peak", 64'(max_occ), 4);
        check("stream_occ_end", 64'(occupancy), 0);

        // Fill with out_ready low, then hold full for 5 cycles
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            cyc(); in_valid = 1'b1; in_id = 16'(100 + k);
        end
        for (int s = 0; s < 5; s++) begin
            cyc(); in_valid = 1'b1; in_id = 16'd104;
            smp();
            check("stall_stage_en", 64'(stage_en), 0);
            check("stall_in_ready", 64'(in_ready), 0);
            check("stall_stage_vld", 64'(stage_vld), 64'hF);
            check("stall_occ", 64'(occupancy), 4);
        end
        cyc(); in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) cyc();
        smp(); check("stall_drain_occ", 64'(occupancy), 0);

        // Modulus change with occupancy 3 and a simultaneous operand accept
        for (int k = 0; k < 3; k++) begin
            cyc(); in_valid = 1'b1; in_id = 16'(200 + k);
        end
        cyc(); in_id = 16'd203; cfg_valid = 1'b1; cfg_n = 64'h1234;
        smp();
        check("chg_occ", 64'(occupancy), 3);
        check("chg_cfg_ready", 64'(cfg_ready), 1);
        check("chg_in_ready", 64'(in_ready), 1);
        for (int d = 0; d < 4; d++) begin
            cyc(); cfg_valid = 1'b0; in_valid = 1'b0;
            smp();
            if (d == 0) check("drain_occ_full", 64'(occupancy), 4);
            check("drain_n_cur", n_cur, 64'hFFFF_FFFF);
            check("drain_in_ready", 64'(in_ready), 0);
            check("drain_cfg_ready", 64'(cfg_ready), 0);
            check("drain_busy", 64'(busy), 1);
        end
        cyc(); smp();
        check("reload_occ", 64'(occupancy), 0);
        check("reload_n_cur_old", n_cur, 64'hFFFF_FFFF);
        check("reload_in_ready", 64'(in_ready), 0);
        check("reload_cfg_ready", 64'(cfg_ready), 0);
        cyc(); smp();
        check("newmod_n_cur", n_cur, 64'h1234);
        check("newmod_in_ready", 64'(in_ready), 1);

        // Stream under the new modulus, then reset with a full pipe
        exp_n = 64'h1234;
        for (int k = 0; k < 6; k++) begin
            cyc(); in_valid = 1'b1; in_id = 16'(300 + k);
        end
        smp();
        check("prerst_occ", 64'(occupancy), 4);
        check("prerst_stage_vld", 64'(stage_vld), 64'hF);
        #2 rst_n = 1'b0; in_valid = 1'b0;
        #1;
        check("midrst_stage_vld", 64'(stage_vld), 0);
        check("midrst_out_valid", 64'(out_valid), 0);
        check("midrst_n_cur", n_cur, 0);
        check("midrst_in_ready", 64'(in_ready), 0);
        check("midrst_cfg_ready", 64'(cfg_ready), 1);
        check("midrst_occ", 64'(occupancy), 0);
        check("midrst_busy", 64'(busy), 0);
        sb.delete();
        cyc(); rst_n = 1'b1;

`ifdef R16_MODRED_CTRL_PERF_EN
        cfg_valid = 1'b1; cfg_n = 64'hFFFF_FFFF;
        cyc(); cfg_valid = 1'b0;
        cyc(); exp_n = 64'hFFFF_FFFF; out_ready = 1'b0; in_valid = 1'b1; in_id = 16'd400;
        for (int k = 1; k < 4; k++) begin
            cyc(); in_id = 16'(400 + k);
        end
        cyc(); in_valid = 1'b0;
        smp(); check("perf_cnt_start", 64'(stall_cnt), 0);
        repeat (7) cyc();
        smp(); check("perf_cnt_7", 64'(stall_cnt), 7);
        cyc(); stall_clr = 1'b1;
        cyc(); stall_clr = 1'b0;
        smp(); check("perf_cnt_clr", 64'(stall_cnt), 0);
        out_ready = 1'b1;
`endif

        repeat (8) cyc();
        smp();
        check("sb_empty", 64'(sb.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
